key_note_arbiter: RTL and testbench

//   Keyboard front end for the note tone generators (C4..C5, 8 notes, 25 MHz clk).

---
 rtl/key_note_arbiter.sv | 147 ++++++++++++++
 tb/tb_key_note_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_note_arbiter.sv
// key_note_arbiter: debounces piano keys, arbitrates to one note, gates generator enables and muxes the speaker; SUSTAIN_EN adds a release hold
module key_note_arbiter #(
  parameter int NUM_KEYS        = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GAP_CYCLES      = 2500,
  parameter int SUSTAIN_CYCLES  = 12500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_KEYS-1:0] tone_in,
  output logic [NUM_KEYS-1:0] note_en,
  output logic                speaker,
  output logic [2:0]          note_idx,
  output logic                note_valid
);
  localparam int DW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef SUSTAIN_EN
  localparam int SW = SUSTAIN_CYCLES > 0 ? $clog2(SUSTAIN_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, GAP, PLAY, SUSTAIN} state_t;
  logic [SW-1:0] sus_cnt, sus_n;
  logic sus_done;
  assign sus_done = int'(sus_cnt) + 1 >= SUSTAIN_CYCLES;
`else
  typedef enum logic [1:0] {IDLE, GAP, PLAY} state_t;
`endif
  state_t state, state_n;
  logic [NUM_KEYS-1:0] sync1, sync2, key_db, key_db_q, press;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [2:0] target, target_n, cur, cur_n, winner, lowest;
  logic active, gap_done;
  // two-flop synchroniser plus the previous debounced level for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync1, sync2, key_db_q} <= '0;
    else {sync1, sync2, key_db_q} <= {key_raw, sync1, key_db};
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic db;
    assign key_db[i] = db;
    // accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        db  <= 1'b0;
      end else if (sync2[i] == db) cnt <= '0;
      else if (int'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
        cnt <= '0;
        db  <= sync2[i];
      end else cnt <= cnt + DW'(1);
  end
  assign press    = key_db & ~key_db_q;
  assign gap_done = int'(gap_cnt) + 1 >= GAP_CYCLES;
  // lowest-index newly pressed key and lowest-index held key
  always_comb begin
    winner = '0;
    lowest = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i]) winner = 3'(i);
      if (key_db[i]) lowest = 3'(i);
    end
  end
  // state, target, sounding note and counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      target  <= '0;
      cur     <= '0;
      gap_cnt <= '0;
`ifdef SUSTAIN_EN
      sus_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      target  <= target_n;
      cur     <= cur_n;
      gap_cnt <= gap_n;
`ifdef SUSTAIN_EN
      sus_cnt <= sus_n;
`endif
    end
  // next-state logic; a fresh press always beats a release in the same cycle
  always_comb begin
    state_n  = state;
    target_n = target;
    cur_n    = cur;
    gap_n    = gap_cnt;
`ifdef SUSTAIN_EN
    sus_n    = sus_cnt;
`endif
    case (state)
      IDLE: if (|press) begin
        state_n  = GAP;
        target_n = winner;
        gap_n    = '0;
      end
      GAP: begin
        target_n = |press ? winner : key_db[target] ? target : lowest;
        gap_n    = gap_done ? gap_cnt : gap_cnt + GW'(1);
        if (~|key_db) state_n = IDLE;
        else if (gap_done) begin
          state_n = PLAY;
          cur_n   = target_n;
        end
      end
      PLAY: if (|press) begin
        state_n  = GAP;
        target_n = winner;
        gap_n    = '0;
      end else if (!key_db[cur]) begin
        if (|key_db) begin
          state_n  = GAP;
          target_n = lowest;
          gap_n    = '0;
        end else begin
`ifdef SUSTAIN_EN
          state_n = SUSTAIN;
          sus_n   = '0;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef SUSTAIN_EN
      SUSTAIN: if (|press) begin
        state_n  = GAP;
        target_n = winner;
        gap_n    = '0;
      end else if (sus_done) state_n = IDLE;
      else sus_n = sus_cnt + SW'(1);
`endif
      default: state_n = IDLE;
    endcase
  end
`ifdef SUSTAIN_EN
  assign active = state == PLAY || state == SUSTAIN;
`else
  assign active = state == PLAY;
`endif
  assign note_en    = active ? NUM_KEYS'(1) << cur : '0;
  assign note_idx   = active ? cur : 3'd0;
  assign note_valid = active;
  // registered speaker mux, silent outside the sounding states
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) speaker <= 1'b0;
    else speaker <= active & tone_in[cur];
endmodule

// File: tb/tb_key_note_arbiter.sv
// tb_key_note_arbiter: directed checks of debounce, arbitration, gap timing, release and reset
module tb_key_note_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] key_raw = '0;
  logic [7:0] tone_in = '0;
  logic [7:0] note_en;
  logic speaker, note_valid;
  logic [2:0] note_idx;
  int checks = 0;
  int fails = 0;

  key_note_arbiter #(.NUM_KEYS(8), .DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .SUSTAIN_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .tone_in(tone_in),
    .note_en(note_en), .speaker(speaker), .note_idx(note_idx), .note_valid(note_valid)
  );

  always #20 clk = ~clk;
  always @(posedge clk) tone_in <= tone_in + 8'd1;

  task wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_raw = 8'(i * 37 + 1);
      @(negedge clk);
      checks++;
      if (note_en !== 8'h00 || speaker !== 1'b0 || note_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: note_en=%h speaker=%b note_valid=%b, required 00 0 0", note_en, speaker, note_valid);
      end
    end
    key_raw = '0;
    rst_n = 1'b1;
    wait_n(12);
    checks++;
    if (note_en !== 8'h00 || note_valid !== 1'b0 || note_idx !== 3'd0) begin
      fails++;
      $display("FAIL reset_idle: note_en=%h note_valid=%b note_idx=%0d, required 00 0 0", note_en, note_valid, note_idx);
    end
  endtask

  task test_debounce;
    logic [7:0] prev;
    repeat (3) begin
      key_raw = 8'h01;
      wait_n(3);
      key_raw = 8'h00;
      wait_n(3);
    end
    key_raw = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      wait_n(1);
      checks++;
      if (note_en !== (k == 9 ? 8'h01 : 8'h00)) begin
        fails++;
        $display("FAIL debounce_latency k=%0d: note_en=%h, required %h", k, note_en, (k == 9 ? 8'h01 : 8'h00));
      end
    end
    checks++;
    if (note_idx !== 3'd0 || note_valid !== 1'b1) begin
      fails++;
      $display("FAIL debounce_idx: note_idx=%0d note_valid=%b, required 0 1", note_idx, note_valid);
    end
    prev = tone_in;
    for (int k = 0; k < 8; k++) begin
      wait_n(1);
      checks++;
      if (speaker !== prev[0]) begin
        fails++;
        $display("FAIL speaker_delay k=%0d: speaker=%b, required %b", k, speaker, prev[0]);
      end
      prev = tone_in;
    end
    key_raw = 8'h00;
    wait_n(16);
    checks++;
    if (note_en !== 8'h00 || speaker !== 1'b0) begin
      fails++;
      $display("FAIL debounce_release: note_en=%h speaker=%b, required 00 0", note_en, speaker);
    end
  endtask

  task test_back_to_back;
    key_raw = 8'h04;
    wait_n(9);
    checks++;
    if (note_en !== 8'h04) begin
      fails++;
      $display("FAIL b2b_first: note_en=%h, required 04", note_en);
    end
    key_raw = 8'h24;
    wait_n(6);
    checks++;
    if (note_en !== 8'h04) begin
      fails++;
      $display("FAIL b2b_before_gap: note_en=%h, required 04", note_en);
    end
    for (int k = 7; k <= 9; k++) begin
      wait_n(1);
      checks++;
      if (note_en !== (k == 9 ? 8'h20 : 8'h00)) begin
        fails++;
        $display("FAIL b2b_switch k=%0d: note_en=%h, required %h", k, note_en, (k == 9 ? 8'h20 : 8'h00));
      end
    end
    checks++;
    if (note_idx !== 3'd5) begin
      fails++;
      $display("FAIL b2b_idx: note_idx=%0d, required 5", note_idx);
    end
    key_raw = 8'h04;
    wait_n(7);
    checks++;
    if (note_en !== 8'h00) begin
      fails++;
      $display("FAIL b2b_release_gap: note_en=%h, required 00", note_en);
    end
    wait_n(2);
    checks++;
    if (note_en !== 8'h04 || note_idx !== 3'd2) begin
      fails++;
      $display("FAIL b2b_return: note_en=%h note_idx=%0d, required 04 2", note_en, note_idx);
    end
  endtask

  task test_release;
    key_raw = 8'h00;
    wait_n(6);
    checks++;
    if (note_en !== 8'h04) begin
      fails++;
      $display("FAIL release_still: note_en=%h, required 04", note_en);
    end
    wait_n(1);
`ifdef SUSTAIN_EN
    checks++;
    if (note_en !== 8'h04 || note_valid !== 1'b1) begin
      fails++;
      $display("FAIL sustain_start: note_en=%h note_valid=%b, required 04 1", note_en, note_valid);
    end
    wait_n(7);
    checks++;
    if (note_en !== 8'h04) begin
      fails++;
      $display("FAIL sustain_last: note_en=%h, required 04", note_en);
    end
    wait_n(1);
    checks++;
    if (note_en !== 8'h00 || note_valid !== 1'b0) begin
      fails++;
      $display("FAIL sustain_expire: note_en=%h note_valid=%b, required 00 0", note_en, note_valid);
    end
    key_raw = 8'h04;
    wait_n(9);
    key_raw = 8'h00;
    wait_n(4);
    key_raw = 8'h02;
    wait_n(6);
    checks++;
    if (note_en !== 8'h04) begin
      fails++;
      $display("FAIL sustain_press_hold: note_en=%h, required 04", note_en);
    end
    wait_n(1);
    checks++;
    if (note_en !== 8'h00) begin
      fails++;
      $display("FAIL sustain_press_gap: note_en=%h, required 00", note_en);
    end
    wait_n(2);
    checks++;
    if (note_en !== 8'h02 || note_idx !== 3'd1) begin
      fails++;
      $display("FAIL sustain_press_new: note_en=%h note_idx=%0d, required 02 1", note_en, note_idx);
    end
    key_raw = 8'h00;
    wait_n(20);
`else
    checks++;
    if (note_en !== 8'h00 || note_valid !== 1'b0 || note_idx !== 3'd0) begin
      fails++;
      $display("FAIL release_silent: note_en=%h note_valid=%b note_idx=%0d, required 00 0 0", note_en, note_valid, note_idx);
    end
    wait_n(4);
`endif
  endtask

  task test_simultaneous;
    key_raw = 8'h48;
    wait_n(8);
    checks++;
    if (note_en !== 8'h00) begin
      fails++;
      $display("FAIL simul_gap: note_en=%h, required 00", note_en);
    end
    wait_n(1);
    checks++;
    if (note_en !== 8'h08 || note_idx !== 3'd3 || note_valid !== 1'b1) begin
      fails++;
      $display("FAIL simul_winner: note_en=%h note_idx=%0d note_valid=%b, required 08 3 1", note_en, note_idx, note_valid);
    end
  endtask

  task test_async_reset;
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if (note_en !== 8'h00 || speaker !== 1'b0 || note_valid !== 1'b0 || note_idx !== 3'd0) begin
      fails++;
      $display("FAIL async_reset: note_en=%h speaker=%b note_valid=%b note_idx=%0d, required 00 0 0 0", note_en, speaker, note_valid, note_idx);
    end
    key_raw = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(10);
    checks++;
    if (note_en !== 8'h00 || note_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_idle: note_en=%h note_valid=%b, required 00 0", note_en, note_valid);
    end
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_back_to_back;
    test_release;
    test_simultaneous;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
